// File: rtl/fifo_protocol_monitor.sv
// Passive cycle-by-cycle checker for a synchronous FIFO. It keeps a shadow occupancy model and compares the DUT flags and handshakes with it.
// Define FIFO_MON_DATA_CHECK_EN to add a shadow memory and a read-data integrity check (bit 7).
module fifo_protocol_monitor #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int AF_TH      = DEPTH - 1,
    parameter int AE_TH      = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic                         rd_en,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic [DATA_WIDTH-1:0]        data_out,
    input  logic                         full,
    input  logic                         empty,
    input  logic                         almostfull,
    input  logic                         almostempty,
    input  logic                         wr_ack,
    input  logic                         overflow,
    input  logic                         underflow,
    input  logic                         clr_err,
    output logic [7:0]                   err_flags,
    output logic                         err_valid,
    output logic [7:0]                   first_err,
    output logic [CNT_WIDTH-1:0]         err_count,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    localparam logic [OCC_W-1:0]     OCC_ZERO = {OCC_W{1'b0}};
    localparam logic [OCC_W-1:0]     OCC_ONE  = OCC_W'(1'b1);
    localparam logic [OCC_W-1:0]     DEPTH_C  = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0]     AF_C     = OCC_W'(AF_TH);
    localparam logic [OCC_W-1:0]     AE_C     = OCC_W'(AE_TH);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1'b1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    logic [OCC_W-1:0] count_r;
    logic [OCC_W-1:0] count_nxt_s;
    logic             wr_acc_s;
    logic             rd_acc_s;
    logic             exp_full_s;
    logic             exp_empty_s;
    logic             exp_af_s;
    logic             exp_ae_s;
    logic             exp_wr_ack_r;
    logic             exp_ovf_r;
    logic             exp_udf_r;
    logic [7:0]       check_s;
    logic             err_any_s;
    logic [7:0]       err_flags_r;
    logic             err_valid_r;
    logic [7:0]       first_err_r;
    logic [CNT_WIDTH-1:0] err_count_r;

    // Expected status flags and request acceptance, all decoded from the current shadow count.
    always_comb begin
        exp_full_s  = (count_r == DEPTH_C);
        exp_empty_s = (count_r == OCC_ZERO);
        exp_af_s    = (count_r == AF_C);
        exp_ae_s    = (count_r == AE_C);
        wr_acc_s    = wr_en && !exp_full_s;
        rd_acc_s    = rd_en && !exp_empty_s;
    end

    // Next shadow occupancy; a simultaneous accepted write and read cancel out.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + OCC_ONE;
            2'b01:   count_nxt_s = count_r - OCC_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Shadow occupancy and expected registered handshakes for the next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r      <= OCC_ZERO;
            exp_wr_ack_r <= 1'b0;
            exp_ovf_r    <= 1'b0;
            exp_udf_r    <= 1'b0;
        end else begin
            count_r      <= count_nxt_s;
            exp_wr_ack_r <= wr_acc_s;
            exp_ovf_r    <= wr_en && exp_full_s;
            // A read paired with a write at empty is absorbed by the write, so no underflow.
            exp_udf_r    <= rd_en && exp_empty_s && !wr_en;
        end
    end

`ifdef FIFO_MON_DATA_CHECK_EN
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic                  exp_rd_valid_r;
    logic [DATA_WIDTH-1:0] exp_data_r;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? PTR_ZERO : (ptr + PTR_ONE);
    endfunction

    // Shadow memory contents survive reset; only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Shadow pointers and the read data expected on data_out next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r       <= PTR_ZERO;
            rd_ptr_r       <= PTR_ZERO;
            exp_rd_valid_r <= 1'b0;
            exp_data_r     <= {DATA_WIDTH{1'b0}};
        end else begin
            exp_rd_valid_r <= rd_acc_s;
            if (wr_acc_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_acc_s) begin
                rd_ptr_r   <= next_ptr(rd_ptr_r);
                exp_data_r <= mem_r[rd_ptr_r];
            end else begin
                rd_ptr_r   <= rd_ptr_r;
                exp_data_r <= exp_data_r;
            end
        end
    end
`else
    logic unused_data_s;
    assign unused_data_s = ^{data_in, data_out};
`endif

    // Per-check mismatch vector for this edge.
    always_comb begin
        check_s    = 8'h00;
        check_s[0] = full        ^ exp_full_s;
        check_s[1] = empty       ^ exp_empty_s;
        check_s[2] = almostfull  ^ exp_af_s;
        check_s[3] = almostempty ^ exp_ae_s;
        check_s[4] = wr_ack      ^ exp_wr_ack_r;
        check_s[5] = overflow    ^ exp_ovf_r;
        check_s[6] = underflow   ^ exp_udf_r;
`ifdef FIFO_MON_DATA_CHECK_EN
        check_s[7] = exp_rd_valid_r && (data_out != exp_data_r);
`else
        check_s[7] = 1'b0;
`endif
        err_any_s  = |check_s;
    end

    // Error reporting; a failure in the same cycle as clr_err restarts the record with that failure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_flags_r <= 8'h00;
            err_valid_r <= 1'b0;
            first_err_r <= 8'h00;
            err_count_r <= CNT_ZERO;
        end else begin
            err_valid_r <= err_any_s;
            if (clr_err) begin
                err_flags_r <= check_s;
                first_err_r <= check_s;
                err_count_r <= err_any_s ? CNT_ONE : CNT_ZERO;
            end else if (err_any_s) begin
                err_flags_r <= err_flags_r | check_s;
                first_err_r <= (first_err_r == 8'h00) ? check_s : first_err_r;
                err_count_r <= (err_count_r == CNT_MAX) ? err_count_r : (err_count_r + CNT_ONE);
            end else begin
                err_flags_r <= err_flags_r;
                first_err_r <= first_err_r;
                err_count_r <= err_count_r;
            end
        end
    end

    assign err_flags = err_flags_r;
    assign err_valid = err_valid_r;
    assign first_err = first_err_r;
    assign err_count = err_count_r;
    assign occupancy = count_r;

endmodule

// File: tb/tb_fifo_protocol_monitor.sv
// Directed bench: a well-behaved reference FIFO drives the monitor, and xor masks plant
// flag/handshake/data faults on chosen cycles. Expected monitor outputs are hand-computed.
module tb_fifo_protocol_monitor;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic        rd_en;
    logic [15:0] data_in;
    logic        clr_err;
    logic [6:0]  inj;
    logic [15:0] data_flip;

    logic [7:0]  err_flags;
    logic        err_valid;
    logic [7:0]  first_err;
    logic [3:0]  err_count;
    logic [3:0]  occupancy;

    int          checks_cnt;
    int          errors_cnt;

`ifdef FIFO_MON_DATA_CHECK_EN
    localparam logic [7:0] DATA_ERR = 8'h80;
`else
    localparam logic [7:0] DATA_ERR = 8'h00;
`endif

    // Reference FIFO (depth 8) standing in for the DUT being monitored.
    int          f_cnt;
    int          f_wp;
    int          f_rp;
    logic [15:0] f_mem [8];
    logic        f_ack;
    logic        f_ovf;
    logic        f_udf;
    logic [15:0] f_dout;
    logic        f_wa;
    logic        f_ra;

    assign f_wa = wr_en && (f_cnt != 8);
    assign f_ra = rd_en && (f_cnt != 0);

    always @(posedge clk) begin
        if (!rst_n) begin
            f_cnt  <= 0;
            f_wp   <= 0;
            f_rp   <= 0;
            f_ack  <= 1'b0;
            f_ovf  <= 1'b0;
            f_udf  <= 1'b0;
            f_dout <= 16'h0000;
        end else begin
            f_ack <= f_wa;
            f_ovf <= wr_en && (f_cnt == 8);
            f_udf <= rd_en && (f_cnt == 0) && !wr_en;
            if (f_wa) begin
                f_mem[f_wp] <= data_in;
                f_wp        <= (f_wp + 1) % 8;
            end
            if (f_ra) begin
                f_dout <= f_mem[f_rp];
                f_rp   <= (f_rp + 1) % 8;
            end
            f_cnt <= f_cnt + (f_wa ? 1 : 0) - (f_ra ? 1 : 0);
        end
    end

    logic        full_s, empty_s, af_s, ae_s, ack_s, ovf_s, udf_s;
    logic [15:0] dout_s;
    assign full_s  = (f_cnt == 8) ^ inj[0];
    assign empty_s = (f_cnt == 0) ^ inj[1];
    assign af_s    = (f_cnt == 7) ^ inj[2];
    assign ae_s    = (f_cnt == 1) ^ inj[3];
    assign ack_s   = f_ack ^ inj[4];
    assign ovf_s   = f_ovf ^ inj[5];
    assign udf_s   = f_udf ^ inj[6];
    assign dout_s  = f_dout ^ data_flip;

    fifo_protocol_monitor #(
        .DATA_WIDTH (16),
        .DEPTH      (8),
        .AF_TH      (7),
        .AE_TH      (1),
        .CNT_WIDTH  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .data_in     (data_in),
        .data_out    (dout_s),
        .full        (full_s),
        .empty       (empty_s),
        .almostfull  (af_s),
        .almostempty (ae_s),
        .wr_ack      (ack_s),
        .overflow    (ovf_s),
        .underflow   (udf_s),
        .clr_err     (clr_err),
        .err_flags   (err_flags),
        .err_valid   (err_valid),
        .first_err   (first_err),
        .err_count   (err_count),
        .occupancy   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_errors();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        rst_n      = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        data_in    = 16'h0000;
        clr_err    = 1'b0;
        inj        = 7'h00;
        data_flip  = 16'h0000;

        // Reset state
        repeat (3) tick();
        check_eq("rst_flags", 32'(err_flags), 32'h00);
        check_eq("rst_valid", 32'(err_valid), 32'h0);
        check_eq("rst_first", 32'(first_err), 32'h00);
        check_eq("rst_count", 32'(err_count), 32'h0);
        check_eq("rst_occ",   32'(occupancy), 32'h0);
        rst_n = 1'b1;
        tick();
        check_eq("idle_flags", 32'(err_flags), 32'h00);

        // Fill with 0x0001..0x0008
        for (int i = 1; i <= 8; i++) begin
            wr_en   = 1'b1;
            data_in = 16'(i);
            tick();
        end
        wr_en = 1'b0;
        tick();
        check_eq("fill_occ",   32'(occupancy), 32'h8);
        check_eq("fill_flags", 32'(err_flags), 32'h00);
        check_eq("fill_count", 32'(err_count), 32'h0);
        check_eq("fill_valid", 32'(err_valid), 32'h0);

        // Write into a full FIFO; DUT overflow held at 0
        wr_en   = 1'b1;
        data_in = 16'h00FF;
        tick();
        wr_en = 1'b0;
        inj   = 7'h20;
        tick();
        inj = 7'h00;
        check_eq("ovf_flags", 32'(err_flags), 32'h20);
        check_eq("ovf_first", 32'(first_err), 32'h20);
        check_eq("ovf_count", 32'(err_count), 32'h1);
        check_eq("ovf_valid", 32'(err_valid), 32'h1);
        check_eq("ovf_occ",   32'(occupancy), 32'h8);
        tick();
        check_eq("ovf_valid_drop", 32'(err_valid), 32'h0);
        check_eq("ovf_count_hold", 32'(err_count), 32'h1);
        clear_errors();
        check_eq("clr_flags", 32'(err_flags), 32'h00);
        check_eq("clr_first", 32'(first_err), 32'h00);
        check_eq("clr_count", 32'(err_count), 32'h0);

        // Drain; data 0x0001..0x0008 must match
        for (int i = 1; i <= 8; i++) begin
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        tick();
        check_eq("drain_occ",   32'(occupancy), 32'h0);
        check_eq("drain_count", 32'(err_count), 32'h0);

        // Write+read together at empty, DUT wrongly raises underflow
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        data_in = 16'h1234;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        inj   = 7'h40;
        tick();
        inj = 7'h00;
        check_eq("both_empty_occ",   32'(occupancy), 32'h1);
        check_eq("both_empty_flags", 32'(err_flags), 32'h40);
        clear_errors();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
        check_eq("both_empty_read_count", 32'(err_count), 32'h0);
        check_eq("both_empty_read_occ",   32'(occupancy), 32'h0);

        // Corrupted read data 0xA5A5 -> 0xA5A4
        wr_en   = 1'b1;
        data_in = 16'hA5A5;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en     = 1'b0;
        data_flip = 16'h0001;
        tick();
        data_flip = 16'h0000;
        check_eq("data_flags", 32'(err_flags), 32'(DATA_ERR));
        check_eq("data_first", 32'(first_err), 32'(DATA_ERR));
        clear_errors();

        // Wrap-around: 20 simultaneous write/read pairs at occupancy 3
        for (int i = 0; i < 3; i++) begin
            wr_en   = 1'b1;
            data_in = 16'h0100 + 16'(i);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            wr_en   = 1'b1;
            rd_en   = 1'b1;
            data_in = 16'h0200 + 16'(i * 7);
            tick();
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        tick();
        check_eq("wrap_occ3", 32'(occupancy), 32'h3);
        repeat (3) begin
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        tick();
        check_eq("wrap_occ0",  32'(occupancy), 32'h0);
        check_eq("wrap_count", 32'(err_count), 32'h0);
        check_eq("wrap_flags", 32'(err_flags), 32'h00);

        // Failure in the same cycle as clr_err
        inj = 7'h40;
        tick();
        tick();
        check_eq("pre_clr_count", 32'(err_count), 32'h2);
        check_eq("pre_clr_first", 32'(first_err), 32'h40);
        inj     = 7'h03;
        clr_err = 1'b1;
        tick();
        inj     = 7'h00;
        clr_err = 1'b0;
        check_eq("clr_hit_count", 32'(err_count), 32'h1);
        check_eq("clr_hit_first", 32'(first_err), 32'h03);
        check_eq("clr_hit_flags", 32'(err_flags), 32'h03);
        check_eq("clr_hit_valid", 32'(err_valid), 32'h1);
        tick();
        check_eq("clr_hit_valid_drop", 32'(err_valid), 32'h0);
        clear_errors();

        // 17 failing cycles saturate a 4-bit count at 15
        inj = 7'h10;
        repeat (17) tick();
        inj = 7'h00;
        check_eq("sat_count", 32'(err_count), 32'hF);
        check_eq("sat_flags", 32'(err_flags), 32'h10);
        tick();
        check_eq("sat_count_hold", 32'(err_count), 32'hF);
        check_eq("sat_valid_drop", 32'(err_valid), 32'h0);
        clear_errors();

        // Reset at occupancy 5; a planted fault during reset is ignored
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            data_in = 16'h0300 + 16'(i);
            tick();
        end
        wr_en = 1'b0;
        tick();
        check_eq("mid_occ5", 32'(occupancy), 32'h5);
        rst_n = 1'b0;
        inj   = 7'h01;
        tick();
        check_eq("mid_rst_occ",   32'(occupancy), 32'h0);
        check_eq("mid_rst_valid", 32'(err_valid), 32'h0);
        check_eq("mid_rst_flags", 32'(err_flags), 32'h00);
        check_eq("mid_rst_count", 32'(err_count), 32'h0);
        inj = 7'h00;
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_flags", 32'(err_flags), 32'h00);
        check_eq("post_rst_occ",   32'(occupancy), 32'h0);
        check_eq("post_rst_count", 32'(err_count), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
